// File: rtl/voting_pkg.sv
// Shared encodings for the voting subsystem: ballot choices, reject codes
// and the ballot issue FSM states, plus a choice-to-vote-line decoder.
package voting_pkg;

    typedef enum logic [1:0] {
        CHOICE_NONE = 2'b00,
        CHOICE_A    = 2'b01,
        CHOICE_B    = 2'b10,
        CHOICE_C    = 2'b11
    } choice_e;

    typedef enum logic [1:0] {
        REJ_NONE   = 2'b00,
        REJ_FULL   = 2'b01,
        REJ_CHOICE = 2'b10
    } reject_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } issue_state_e;

    // Returns {vote_c, vote_b, vote_a}; an invalid choice drives no line.
    function automatic logic [2:0] choice_to_lines(input logic [1:0] choice);
        case (choice)
            CHOICE_A: return 3'b001;
            CHOICE_B: return 3'b010;
            CHOICE_C: return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/ballot_fifo.sv
// Small synchronous ballot FIFO with registered occupancy count.
// A push while full is dropped even if a pop happens on the same edge.
module ballot_fifo
    import voting_pkg::*;
#(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ballot_issue_controller.sv
// Voter-side initiator: buffers booth ballots and replays each one to the
// voting machine as a voter_id setup cycle followed by a one-cycle vote strobe,
// paced by the machine's voting_enabled and busy outputs.
module ballot_issue_controller
    import voting_pkg::*;
#(
    parameter int ID_W       = 4,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ballot_valid,
    input  logic [ID_W-1:0]          ballot_id,
    input  logic [1:0]               ballot_choice,
    output logic                     ballot_ready,
    output logic                     rejected,
    output logic [1:0]               reject_code,
    input  logic                     voting_enabled,
    input  logic                     busy,
    output logic [ID_W-1:0]          voter_id,
    output logic                     vote_a,
    output logic                     vote_b,
    output logic                     vote_c,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    issue_state_e    r_state;
    logic [ID_W-1:0] r_voter_id;
    logic [1:0]      r_choice;
    logic            r_vote_a;
    logic            r_vote_b;
    logic            r_vote_c;
    logic [GW-1:0]   r_gap_cnt;
    logic            r_ballot_ready;
    logic            r_rejected;
    logic [1:0]      r_reject_code;

    logic            w_push;
    logic            w_pop;
    logic [ID_W+1:0] w_head;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_next;
    logic            w_full;
    logic            w_empty;

    assign w_push = ballot_valid & r_ballot_ready & (ballot_choice != CHOICE_NONE);
    assign w_pop  = (r_state == ST_IDLE) & ~w_empty & voting_enabled & ~busy;

    ballot_fifo #(
        .W     (ID_W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({ballot_id, ballot_choice}),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Occupancy after the coming edge, used to register ballot_ready.
    always_comb begin
        w_count_next = w_count;
        if (w_push && !w_pop) begin
            w_count_next = w_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = w_count - CW'(1);
        end
    end

    // Booth-side handshake: ready flag and reject reporting (choice checked first).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ballot_ready <= 1'b1;
            r_rejected     <= 1'b0;
            r_reject_code  <= REJ_NONE;
        end else begin
            r_ballot_ready <= (w_count_next != CW'(DEPTH));
            r_rejected     <= 1'b0;
            if (ballot_valid) begin
                if (ballot_choice == CHOICE_NONE) begin
                    r_rejected    <= 1'b1;
                    r_reject_code <= REJ_CHOICE;
                end else if (!r_ballot_ready) begin
                    r_rejected    <= 1'b1;
                    r_reject_code <= REJ_FULL;
                end
            end
        end
    end

    // Issue FSM: pop, setup voter_id, strobe one vote line, then hold off.
    // The gap counter is loaded with GAP_CYCLES-1 so GAP lasts exactly
    // GAP_CYCLES cycles; with no gap the FSM returns straight to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_voter_id <= '0;
            r_choice   <= CHOICE_NONE;
            r_vote_a   <= 1'b0;
            r_vote_b   <= 1'b0;
            r_vote_c   <= 1'b0;
            r_gap_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_voter_id <= w_head[ID_W+1:2];
                        r_choice   <= w_head[1:0];
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    {r_vote_c, r_vote_b, r_vote_a} <= choice_to_lines(r_choice);
                    r_state <= ST_STROBE;
                end
                ST_STROBE: begin
                    {r_vote_c, r_vote_b, r_vote_a} <= 3'b000;
                    r_gap_cnt <= GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
                    r_state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
                ST_GAP: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - GW'(1);
                    end else if (!busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ballot_ready = r_ballot_ready;
    assign rejected     = r_rejected;
    assign reject_code  = r_reject_code;
    assign voter_id     = r_voter_id;
    assign vote_a       = r_vote_a;
    assign vote_b       = r_vote_b;
    assign vote_c       = r_vote_c;
    assign queue_count  = w_count;

endmodule
